timer_tick_ctrl: RTL and testbench

- Control stage that sits directly upstream of the N-bit load/add counter and also consumes its output.
- Generates prescaled increment strobes into the counter's add port (ADDA/DATA_A).
- Watches the counter's Q_OUT against a programmable compare value.
- On a match it either stops (one-shot) or reloads the counter through the set port (SETC/DATA_C, periodic), and raises a sticky interrupt.

---
 rtl/timer_tick_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_tick_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_ctrl.sv
// Prescaled tick generator and compare/reload controller for an external load/add counter.
// Define TIMER_TICK_CAPTURE_EN to add the CAP_TRIG/CAP_VAL capture port.
module timer_tick_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [1:0]       WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic [WIDTH-1:0] CNT_IN,
    output logic             INC_EN,
    output logic [WIDTH-1:0] INC_VAL,
    output logic             LOAD_EN,
    output logic [WIDTH-1:0] LOAD_VAL,
    output logic             IRQ,
`ifdef TIMER_TICK_CAPTURE_EN
    input  logic             CAP_TRIG,
    output logic [WIDTH-1:0] CAP_VAL,
`endif
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        A_CTRL   = 2'd0,
        A_PRESC  = 2'd1,
        A_CMP    = 2'd2,
        A_RELOAD = 2'd3
    } addr_t;

    state_t             state;
    logic               ctrl_periodic;
    logic               ctrl_irq_en;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;
    logic [WIDTH-1:0]   compare;
    logic [WIDTH-1:0]   reload;
    logic               pending;
    logic [1:0]         blank_cnt;
    logic               inc_en;
    logic               load_en;
    logic               ctrl_wr;
    logic               match;

    assign ctrl_wr = WR_EN && (WR_ADDR == A_CTRL);
    assign match   = (state == RUN) && (blank_cnt == 2'd0) && (CNT_IN >= compare);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            prescale      <= '0;
            presc_cnt     <= '0;
            compare       <= '0;
            reload        <= '0;
            pending       <= 1'b0;
            blank_cnt     <= '0;
            inc_en        <= 1'b0;
            load_en       <= 1'b0;
        end else begin
            load_en <= 1'b0;
            if (blank_cnt != 2'd0)
                blank_cnt <= blank_cnt - 2'd1;

            if (WR_EN) begin
                case (WR_ADDR)
                    A_CTRL: begin
                        ctrl_periodic <= WR_DATA[1];
                        ctrl_irq_en   <= WR_DATA[2];
                    end
                    A_PRESC:  prescale <= WR_DATA[PRESC_W-1:0];
                    A_CMP:    compare  <= WR_DATA;
                    A_RELOAD: reload   <= WR_DATA;
                    default:  ;
                endcase
            end

            // A match in the same cycle as a clear leaves pending set.
            if (match)
                pending <= 1'b1;
            else if (ctrl_wr && WR_DATA[3])
                pending <= 1'b0;

            // Blanking spans the cycle the load is issued plus the cycle the
            // counter output still lags, so the old value cannot re-match.
            if (match && ctrl_periodic) begin
                load_en   <= 1'b1;
                blank_cnt <= 2'd2;
            end

            if (ctrl_wr) begin
                state     <= WR_DATA[0] ? RUN : IDLE;
                presc_cnt <= '0;
                inc_en    <= 1'b0;
            end else if (state == RUN) begin
                if (match && !ctrl_periodic) begin
                    state  <= EXPIRED;
                    inc_en <= 1'b0;
                end else if (presc_cnt == prescale) begin
                    presc_cnt <= '0;
                    inc_en    <= 1'b1;
                end else begin
                    presc_cnt <= presc_cnt + 1'b1;
                    inc_en    <= 1'b0;
                end
            end else begin
                inc_en <= 1'b0;
            end
        end
    end

    assign INC_EN   = inc_en;
    assign INC_VAL  = WIDTH'(1);
    assign LOAD_EN  = load_en;
    assign LOAD_VAL = reload;
    assign IRQ      = pending & ctrl_irq_en;
    assign STATE    = state;

`ifdef TIMER_TICK_CAPTURE_EN
    logic [2:0] cap_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_sync <= '0;
            CAP_VAL  <= '0;
        end else begin
            cap_sync <= {cap_sync[1:0], CAP_TRIG};
            if (cap_sync[1] && !cap_sync[2])
                CAP_VAL <= CNT_IN;
        end
    end
`endif

endmodule

// File: tb/tb_timer_tick_ctrl.sv
// Directed bench for timer_tick_ctrl with an external load/add counter model and a scoreboard queue.
module tb_timer_tick_ctrl;

    localparam int unsigned W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         WR_EN = 1'b0;
    logic [1:0]   WR_ADDR = '0;
    logic [W-1:0] WR_DATA = '0;
    logic [W-1:0] CNT_IN;
    logic         INC_EN;
    logic [W-1:0] INC_VAL;
    logic         LOAD_EN;
    logic [W-1:0] LOAD_VAL;
    logic         IRQ;
    logic [1:0]   STATE;
`ifdef TIMER_TICK_CAPTURE_EN
    logic         CAP_TRIG = 1'b0;
    logic [W-1:0] CAP_VAL;
`endif

    logic         model_on  = 1'b1;
    logic         model_clr = 1'b1;
    logic [W-1:0] model_cnt = '0;
    logic [W-1:0] force_cnt = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    timer_tick_ctrl #(.WIDTH(W), .PRESC_W(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .CNT_IN   (CNT_IN),
        .INC_EN   (INC_EN),
        .INC_VAL  (INC_VAL),
        .LOAD_EN  (LOAD_EN),
        .LOAD_VAL (LOAD_VAL),
        .IRQ      (IRQ),
`ifdef TIMER_TICK_CAPTURE_EN
        .CAP_TRIG (CAP_TRIG),
        .CAP_VAL  (CAP_VAL),
`endif
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    // External counter: load has priority, simultaneous increment lands on top of the load value.
    always @(posedge CLK) begin
        if (model_clr)
            model_cnt <= '0;
        else if (LOAD_EN)
            model_cnt <= LOAD_VAL + {{(W-1){1'b0}}, INC_EN};
        else if (INC_EN)
            model_cnt <= model_cnt + 1;
    end

    assign CNT_IN = model_on ? model_cnt : force_cnt;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [W-1:0] data);
        WR_EN   = 1'b1;
        WR_ADDR = addr;
        WR_DATA = data;
        tick(1);
        WR_EN   = 1'b0;
    endtask

    task automatic expect_v(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] exp_v;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %0h but scoreboard had no expected value", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic wait_cnt(input logic [W-1:0] v, input int max);
        int n = 0;
        while (CNT_IN !== v && n < max) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_load(input int max, output int n);
        n = 0;
        while (LOAD_EN !== 1'b1 && n < max) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;

        // Reset
        tick(2);
        expect_v(0); check("rst_inc_en", W'(INC_EN));
        expect_v(0); check("rst_load_en", W'(LOAD_EN));
        expect_v(0); check("rst_load_val", LOAD_VAL);
        expect_v(0); check("rst_irq", W'(IRQ));
        expect_v(0); check("rst_state", W'(STATE));
        expect_v(1); check("inc_val", INC_VAL);
        RST = 1'b0;
        model_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            expect_v(0); check("idle_inc_en", W'(INC_EN));
        end

        // Prescale 3: pulse every 4 cycles, counter follows one cycle later
        wr(2'd2, 1000);
        wr(2'd1, 3);
        wr(2'd0, 32'h1);
        expect_v(1); check("presc_state", W'(STATE));
        expect_v(0); check("presc_inc0", W'(INC_EN));
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            expect_v((k % 4 == 0) ? 1 : 0); check("presc_inc", W'(INC_EN));
            expect_v((k >= 9) ? 2 : (k >= 5) ? 1 : 0); check("presc_cnt", CNT_IN);
        end
        wr(2'd0, 32'h0);
        expect_v(0); check("disable_state", W'(STATE));
        model_clr = 1'b1;
        tick(1);
        model_clr = 1'b0;

        // One-shot: compare 10, prescale 0
        wr(2'd1, 0);
        wr(2'd2, 10);
        wr(2'd0, 32'h5);
        wait_cnt(10, 50);
        expect_v(10); check("os_reach_cmp", CNT_IN);
        expect_v(1); check("os_state_before", W'(STATE));
        tick(1);
        expect_v(2); check("os_state_expired", W'(STATE));
        expect_v(1); check("os_irq", W'(IRQ));
        tick(5);
        expect_v(11); check("os_final_cnt", CNT_IN);
        expect_v(0); check("os_inc_stopped", W'(INC_EN));
        expect_v(1); check("os_irq_held", W'(IRQ));
        wr(2'd0, 32'h0);
        expect_v(0); check("mask_irq", W'(IRQ));
        wr(2'd0, 32'h4);
        expect_v(1); check("unmask_irq", W'(IRQ));
        wr(2'd0, 32'hC);
        expect_v(0); check("clear_irq", W'(IRQ));
        model_clr = 1'b1;
        tick(1);
        model_clr = 1'b0;

        // Periodic: prescale 1, compare 8, reload 2
        wr(2'd1, 1);
        wr(2'd2, 8);
        wr(2'd3, 2);
        wr(2'd0, 32'h7);
        wait_cnt(8, 60);
        expect_v(8); check("per_reach_cmp", CNT_IN);
        tick(1);
        expect_v(1); check("per_load_en", W'(LOAD_EN));
        expect_v(2); check("per_load_val", LOAD_VAL);
        expect_v(1); check("per_irq", W'(IRQ));
        expect_v(1); check("per_state", W'(STATE));
        tick(1);
        expect_v(0); check("per_load_single", W'(LOAD_EN));
        expect_v(3); check("per_reload_plus_inc", CNT_IN);
        tick(1);
        expect_v(0); check("per_blank", W'(LOAD_EN));
        wait_load(30, n);
        expect_v(12); check("per_period", W'(n + 2));
        wr(2'd0, 32'hF);
        expect_v(0); check("per_clear_irq", W'(IRQ));
        wait_load(40, n);
        expect_v(1); check("per_next_load", W'(LOAD_EN));
        expect_v(1); check("per_irq_again", W'(IRQ));

        // Reload >= compare: a load every third cycle
        wr(2'd3, 20);
        wait_load(40, n);
        expect_v(20); check("rl_load_val", LOAD_VAL);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            expect_v((k % 3 == 0) ? 1 : 0); check("rl_pattern", W'(LOAD_EN));
        end

        // Clear on the match cycle loses to the match
        tick(2);
        expect_v(0); check("cm_pre", W'(LOAD_EN));
        wr(2'd0, 32'hF);
        expect_v(1); check("cm_load", W'(LOAD_EN));
        expect_v(1); check("cm_pending_kept", W'(IRQ));
        wr(2'd0, 32'hF);
        expect_v(0); check("cm_clear_ok", W'(IRQ));
        tick(2);
        expect_v(1); check("cm_rematch_load", W'(LOAD_EN));
        expect_v(1); check("cm_rematch_irq", W'(IRQ));

        // Disable mid-run keeps pending
        wr(2'd0, 32'h4);
        expect_v(0); check("dis_state", W'(STATE));
        expect_v(0); check("dis_inc", W'(INC_EN));
        expect_v(1); check("dis_irq", W'(IRQ));

        // Reset during a load pulse
        wr(2'd0, 32'h7);
        tick(1);
        expect_v(1); check("rstp_load", W'(LOAD_EN));
        RST = 1'b1;
        tick(1);
        expect_v(0); check("rstp_load_off", W'(LOAD_EN));
        expect_v(0); check("rstp_state", W'(STATE));
        expect_v(0); check("rstp_irq", W'(IRQ));
        expect_v(0); check("rstp_load_val", LOAD_VAL);
        RST = 1'b0;

`ifdef TIMER_TICK_CAPTURE_EN
        model_on  = 1'b0;
        force_cnt = 32'h55;
        tick(1);
        CAP_TRIG = 1'b1;
        tick(2);
        expect_v(0); check("cap_not_yet", CAP_VAL);
        tick(1);
        expect_v(32'h55); check("cap_val", CAP_VAL);
        force_cnt = 32'h66;
        CAP_TRIG  = 1'b0;
        tick(5);
        expect_v(32'h55); check("cap_no_fall", CAP_VAL);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
